barrel_pipe: RTL and testbench

BARREL_PIPE -- requirements
Module: barrel_pipe

---
 rtl/barrel_pipe.sv | 99 +++++++++
 tb/tb_barrel_pipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_pipe.sv
// rtl/barrel_pipe.sv - two-stage valid/ready barrel shifter, rotator and bit reverser
// S1 registers the operand; the log2(WIDTH)-level shift network feeds the S2 result register.
module barrel_pipe #(
   parameter int WIDTH = 8,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [SHW-1:0]   in_amt,
   input  logic [2:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_err
);

   localparam logic [2:0] M_SLL = 3'b000;
   localparam logic [2:0] M_SRL = 3'b001;
   localparam logic [2:0] M_SRA = 3'b010;
   localparam logic [2:0] M_ROR = 3'b100;
   localparam logic [2:0] M_REV = 3'b101;
   localparam logic [2:0] M_RRL = 3'b110;
   localparam logic [2:0] M_ILL = 3'b111;

   logic             s1_valid;
   logic [WIDTH-1:0] s1_data;
   logic [SHW-1:0]   s1_amt;
   logic [2:0]       s1_mode;

   logic             s1_load;
   logic             s2_load;
   logic [WIDTH-1:0] stage;
   logic [SHW-1:0]   amt_eff;
   logic             res_err;

   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign s1_load  = in_valid && (!s1_valid || s2_load);
   assign in_ready = !s1_valid || !out_valid || out_ready;

   // Both reversing modes start from the mirrored operand; mode 110 then rotates left.
   always_comb begin
      stage   = s1_data;
      amt_eff = s1_amt;
      res_err = (s1_mode == M_ILL);
      if (s1_mode == M_REV || s1_mode == M_RRL) begin
         for (int i = 0; i < WIDTH; i++) begin
            stage[i] = s1_data[WIDTH-1-i];
         end
      end
      if (s1_mode == M_REV || s1_mode == M_ILL) begin
         amt_eff = '0;
      end
      for (int k = 0; k < SHW; k++) begin
         if (amt_eff[k]) begin
            case (s1_mode)
               M_SLL:   stage = stage << (2**k);
               M_SRL:   stage = stage >> (2**k);
               M_SRA:   stage = $unsigned($signed(stage) >>> (2**k));
               M_ROR:   stage = (stage >> (2**k)) | (stage << (WIDTH - 2**k));
               default: stage = (stage << (2**k)) | (stage >> (WIDTH - 2**k));
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_amt   <= '0;
         s1_mode  <= '0;
      end else if (s1_load) begin
         s1_valid <= 1'b1;
         s1_data  <= in_data;
         s1_amt   <= in_amt;
         s1_mode  <= in_mode;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         out_data  <= stage;
         out_err   <= res_err;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_barrel_pipe.sv
// tb/tb_barrel_pipe.sv - directed and random checks of barrel_pipe against a bitwise model
// A negedge monitor pushes model results on input transfers and pops them on output transfers.
module tb_barrel_pipe;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic [2:0]   in_amt;
   logic [2:0]   in_mode;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_err;

   int checks = 0;
   int errors = 0;
   logic [8:0] sb[$];
   logic [8:0] sb_exp;

   barrel_pipe #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_amt(in_amt), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] model(input logic [W-1:0] d, input logic [2:0] a, input logic [2:0] m);
      logic [W-1:0] r;
      logic [W-1:0] v;
      int s;
      s = int'(a);
      r = '0;
      for (int i = 0; i < W; i++) v[i] = d[W-1-i];
      for (int i = 0; i < W; i++) begin
         case (m)
            3'd0: r[i] = (i >= s) ? d[i-s] : 1'b0;
            3'd1: r[i] = (i + s < W) ? d[i+s] : 1'b0;
            3'd2: r[i] = (i + s < W) ? d[i+s] : d[W-1];
            3'd3: r[(i+s)%W] = d[i];
            3'd4: r[i] = d[(i+s)%W];
            3'd5: r[i] = v[i];
            3'd6: r[(i+s)%W] = v[i];
            default: r[i] = d[i];
         endcase
      end
      return {(m == 3'd7), r};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            check("sb_unexpected_output", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               sb_exp = sb.pop_front();
               check("sb_result", {55'd0, out_err, out_data}, {55'd0, sb_exp});
            end
         end
         if (in_valid && in_ready) sb.push_back(model(in_data, in_amt, in_mode));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] a, input logic [2:0] m);
      in_valid = v;
      in_data  = d;
      in_amt   = a;
      in_mode  = m;
   endtask

   logic [W-1:0] t_data [10] = '{8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h3C, 8'h3C, 8'h96, 8'h5A};
   logic [2:0]   t_amt  [10] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd5};
   logic [2:0]   t_mode [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd0, 3'd2, 3'd6, 3'd7};
   logic [8:0]   t_res  [10] = '{9'h008, 9'h010, 9'h0F0, 9'h00C, 9'h030, 9'h00C, 9'h03C, 9'h03C, 9'h069, 9'h15A};

   logic [8:0] held;

   initial begin
      rst = 1'b1;
      out_ready = 1'b1;
      drive(1'b0, '0, '0, '0);
      step();
      step();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      rst = 1'b0;
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Two-cycle latency of a plain bit reversal.
      drive(1'b1, 8'h96, 3'd3, 3'd5);
      step();
      check("lat_cycle1_valid", 64'(out_valid), 64'd0);
      drive(1'b0, '0, '0, '0);
      step();
      check("lat_cycle2_valid", 64'(out_valid), 64'd1);
      check("lat_rev_data", {55'd0, out_err, out_data}, 64'h069);
      step();

      for (int t = 0; t < 10; t++) begin
         drive(1'b1, t_data[t], t_amt[t], t_mode[t]);
         step();
         drive(1'b0, '0, '0, '0);
         step();
         check($sformatf("table_%0d_valid", t), 64'(out_valid), 64'd1);
         check($sformatf("table_%0d_result", t), {55'd0, out_err, out_data}, {55'd0, t_res[t]});
      end
      step();

      // Eight back-to-back operands must give eight consecutive results.
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) drive(1'b1, W'($urandom), 3'($urandom), 3'($urandom_range(0, 6)));
         else drive(1'b0, '0, '0, '0);
         if (i < 8) check($sformatf("burst_in_ready_%0d", i), 64'(in_ready), 64'd1);
         step();
         if (i >= 1) check($sformatf("burst_out_valid_%0d", i), 64'(out_valid), 64'd1);
      end
      step();
      check("burst_end_valid", 64'(out_valid), 64'd0);

      // Stall: two operands fill the pipe, the third must wait while the result holds.
      out_ready = 1'b0;
      drive(1'b1, 8'hC3, 3'd2, 3'd3);
      held = model(8'hC3, 3'd2, 3'd3);
      step();
      drive(1'b1, 8'h17, 3'd1, 3'd2);
      check("stall_in_ready_b", 64'(in_ready), 64'd1);
      step();
      drive(1'b1, 8'hE4, 3'd6, 3'd4);
      check("stall_full_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("stall_in_ready_%0d", i), 64'(in_ready), 64'd0);
         check($sformatf("stall_out_valid_%0d", i), 64'(out_valid), 64'd1);
         check($sformatf("stall_hold_%0d", i), {55'd0, out_err, out_data}, {55'd0, held});
      end
      out_ready = 1'b1;
      step();
      drive(1'b0, '0, '0, '0);
      step();
      step();
      step();
      check("stall_drained", 64'(out_valid), 64'd0);

      // Random traffic with random backpressure.
      for (int i = 0; i < 80; i++) begin
         drive(1'($urandom), W'($urandom), 3'($urandom), 3'($urandom));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("random_drained", 64'(sb.size()), 64'd0);

      // Reset with both stages full discards everything in flight.
      out_ready = 1'b0;
      drive(1'b1, 8'h11, 3'd1, 3'd0);
      step();
      drive(1'b1, 8'h22, 3'd2, 3'd1);
      step();
      rst = 1'b1;
      step();
      check("flush_out_valid", 64'(out_valid), 64'd0);
      check("flush_in_ready", 64'(in_ready), 64'd1);
      check("flush_out_data", 64'(out_data), 64'd0);
      rst = 1'b0;
      drive(1'b0, '0, '0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("flush_no_stale_%0d", i), 64'(out_valid), 64'd0);
      end
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
